// File: rtl/pwm_pkg.sv
// Shared PWM helpers: capture FSM states, log2 and timeout/counter sizing.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS
  } cap_state_t;

  // floor(log2(v)); log2(0) and log2(1) both return 0
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v;
    while (x > 1) begin
      x = x >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned calc_timeout(input int unsigned clk_hz,
                                               input int unsigned min_hz);
    return clk_hz / min_hz;
  endfunction

  function automatic int unsigned calc_wcnt(input int unsigned clk_hz,
                                            input int unsigned min_hz);
    return log2(calc_timeout(clk_hz, min_hz)) + 1;
  endfunction

endpackage

// File: rtl/pwm_udiv.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
// Caller guarantees dividend[W_DIVIDEND-1:W_QUOT] < divisor so the quotient fits W_QUOT.
module pwm_udiv #(
  parameter int unsigned W_DIVIDEND = 24,
  parameter int unsigned W_QUOT     = 8,
  localparam int unsigned W_DIVISOR = W_DIVIDEND - W_QUOT,
  localparam int unsigned W_ITER    = $clog2(W_QUOT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_abort,
  input  logic                  i_start,
  input  logic [W_DIVIDEND-1:0] i_dividend,
  input  logic [W_DIVISOR-1:0]  i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [W_QUOT-1:0]     o_quot
);

  logic                 r_busy;
  logic                 r_done;
  logic [W_ITER-1:0]    r_iter;
  logic [W_DIVISOR-1:0] r_rem;
  logic [W_DIVISOR-1:0] r_div;
  logic [W_QUOT-1:0]    r_quot;
  logic [W_DIVISOR:0]   w_shift;
  logic [W_DIVISOR:0]   w_diff;
  logic                 w_ge;

  always_comb begin
    w_shift = {r_rem, r_quot[W_QUOT-1]};
    w_diff  = w_shift - {1'b0, r_div};
    w_ge    = (w_shift >= {1'b0, r_div});
  end

  // busy stays high through the done cycle so a start there is ignored
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_iter <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_quot <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_iter <= W_ITER'(W_QUOT);
          r_rem  <= i_dividend[W_DIVIDEND-1:W_QUOT];
          r_quot <= i_dividend[W_QUOT-1:0];
          r_div  <= i_divisor;
        end
      end else if (r_iter != '0) begin
        r_rem  <= w_ge ? w_diff[W_DIVISOR-1:0] : w_shift[W_DIVISOR-1:0];
        r_quot <= {r_quot[W_QUOT-2:0], w_ge};
        r_iter <= r_iter - W_ITER'(1);
        if (r_iter == W_ITER'(1)) r_done <= 1'b1;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and normalised duty of an external PWM input,
// flagging loss of signal and periods dropped while the divider is busy.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned sys_clk        = 100_000_000,
  parameter int unsigned min_freq       = 1000,
  parameter int unsigned bit_resolution = 8,
  localparam int unsigned TIMEOUT = calc_timeout(sys_clk, min_freq),
  localparam int unsigned W_CNT   = calc_wcnt(sys_clk, min_freq)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      pwm_in,
  output logic [bit_resolution-1:0] duty,
  output logic [W_CNT-1:0]          period,
  output logic [W_CNT-1:0]          high_time,
  output logic                      valid,
  output logic                      lost,
  output logic                      overrun
);

  logic r_s1, r_s2, r_s3;
  logic w_rise, w_fall;

  cap_state_t r_state, w_state_nxt;

  logic [W_CNT-1:0] r_cnt, r_high, r_pend_period, r_pend_high;
  logic w_cnt_load, w_cnt_inc, w_cnt_clr, w_high_latch;
  logic w_start, w_overrun, w_timeout;

  logic                          w_div_busy, w_div_done;
  logic [bit_resolution-1:0]     w_quot;
  logic [W_CNT+bit_resolution-1:0] w_dividend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_high_latch = 1'b0;
    w_start      = 1'b0;
    w_overrun    = 1'b0;
    w_timeout    = 1'b0;
    if (!ena) begin
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_ARM;
            w_cnt_load  = 1'b1;
          end
        end
        ST_ARM, ST_MEAS: begin
          if (w_rise) begin
            w_state_nxt = ST_MEAS;
            w_cnt_load  = 1'b1;
            if (w_div_busy) w_overrun = 1'b1;
            else            w_start   = 1'b1;
          end else if (r_cnt == W_CNT'(TIMEOUT)) begin
            w_state_nxt = ST_IDLE;
            w_timeout   = 1'b1;
            w_cnt_clr   = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
          if (w_fall) w_high_latch = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // cnt restarts at 1 on a rising edge so the next edge samples the exact period
  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) begin
      r_cnt  <= '0;
      r_high <= '0;
    end else begin
      if (w_cnt_load)     r_cnt <= W_CNT'(1);
      else if (w_cnt_inc) r_cnt <= r_cnt + W_CNT'(1);
      if (w_high_latch)   r_high <= r_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_period <= '0;
      r_pend_high   <= '0;
    end else if (w_start) begin
      r_pend_period <= r_cnt;
      r_pend_high   <= r_high;
    end
  end

  assign w_dividend = {r_high, {bit_resolution{1'b0}}};

  pwm_udiv #(
    .W_DIVIDEND(W_CNT + bit_resolution),
    .W_QUOT    (bit_resolution)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_abort   (~ena),
    .i_start   (w_start),
    .i_dividend(w_dividend),
    .i_divisor (r_cnt),
    .o_busy    (w_div_busy),
    .o_done    (w_div_done),
    .o_quot    (w_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      duty      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      lost      <= 1'b1;
      overrun   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= w_overrun;
      if (w_timeout) begin
        duty      <= r_s2 ? '1 : '0;
        period    <= '0;
        high_time <= '0;
        lost      <= 1'b1;
        valid     <= 1'b1;
      end else if (w_div_done && ena) begin
        duty      <= w_quot;
        period    <= r_pend_period;
        high_time <= r_pend_high;
        lost      <= 1'b0;
        valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a pin-level model queues expected results.
module tb_pwm_capture;

  localparam int unsigned R  = 8;
  localparam int unsigned TO = 2000;
  localparam int unsigned WC = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          pwm_in;
  logic [R-1:0]  duty;
  logic [WC-1:0] period;
  logic [WC-1:0] high_time;
  logic          valid;
  logic          lost;
  logic          overrun;

  pwm_capture #(
    .sys_clk       (100_000_000),
    .min_freq      (50_000),
    .bit_resolution(R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .pwm_in   (pwm_in),
    .duty     (duty),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .lost     (lost),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int per;
    int hi;
    int lost;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   oq[$];
  exp_t last_exp;
  exp_t mon_e;

  int n_vec = 0;
  int n_bad = 0;

  bit m_armed = 1'b0;
  bit m_ena   = 1'b1;
  int m_rise  = 0;
  int m_fall  = 0;
  int m_busy_until = -1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input int p, input int h, input int l, input int c);
    exp_t e;
    e.duty = d; e.per = p; e.hi = h; e.lost = l; e.cyc = c;
    q.push_back(e);
    last_exp = e;
  endtask

  // one cycle; timeout fires TO cycles after the detected (pin+2) rising edge
  task automatic step();
    @(negedge clk);
    if (m_armed && m_ena && cyc == m_rise + int'(TO) + 2) begin
      push_exp(pwm_in ? int'((1 << R) - 1) : 0, 0, 0, 1, cyc + 1);
      m_armed = 1'b0;
    end
  endtask

  task automatic set_pin(input logic v);
    step();
    if (v && !pwm_in && m_ena) begin
      if (m_armed) begin
        if (cyc + 2 <= m_busy_until) begin
          oq.push_back(cyc + 3);
        end else begin
          push_exp(((m_fall - m_rise) << R) / (cyc - m_rise), cyc - m_rise,
                   m_fall - m_rise, 0, cyc + int'(R) + 4);
          m_busy_until = cyc + 2 + int'(R) + 1;
        end
      end
      m_armed = 1'b1;
      m_rise  = cyc;
    end
    if (!v && pwm_in) m_fall = cyc;
    pwm_in = v;
  endtask

  task automatic pulse(input int p, input int h);
    set_pin(1'b1);
    repeat (h - 1) step();
    set_pin(1'b0);
    repeat (p - h - 1) step();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_duty"}, duty, 0);
    chk({pfx, "_period"}, period, 0);
    chk({pfx, "_high"}, high_time, 0);
    chk({pfx, "_valid"}, valid, 0);
    chk({pfx, "_lost"}, lost, 1);
    chk({pfx, "_overrun"}, overrun, 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("valid_cycle", cyc, mon_e.cyc);
          chk("duty", duty, mon_e.duty);
          chk("period", period, mon_e.per);
          chk("high_time", high_time, mon_e.hi);
          chk("lost", lost, mon_e.lost);
        end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        chk("valid_missing", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (overrun) begin
        if (oq.size() == 0) chk("spurious_overrun", 1, 0);
        else                chk("overrun_cycle", cyc, oq.pop_front());
      end else if (oq.size() != 0 && cyc > oq[0]) begin
        chk("overrun_missing", cyc, oq[0]);
        void'(oq.pop_front());
      end
    end
  end

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    step();
    rst = 1'b0;

    // first rise only arms; later periods produce results
    repeat (3) pulse(100, 25);
    pulse(100, 99);
    pulse(100, 1);
    repeat (2) pulse(1000, 500);

    // stuck low, then stuck high, then recovery
    repeat (TO + 50) step();
    set_pin(1'b1);
    repeat (TO + 50) step();
    set_pin(1'b0);
    repeat (10) step();
    repeat (2) pulse(100, 50);

    // periods shorter than the divider latency
    repeat (6) pulse(5, 2);
    repeat (2) pulse(100, 25);

    // reset while a division is in flight
    set_pin(1'b1);
    step();
    set_pin(1'b0);
    repeat (3) step();
    step();
    rst = 1'b1;
    q.delete();
    oq.delete();
    m_armed = 1'b0;
    m_busy_until = -1;
    step();
    chk_reset_vals("midrst");
    step();
    rst = 1'b0;

    repeat (3) pulse(100, 25);

    // disabled capture holds outputs
    step();
    ena   = 1'b0;
    m_ena = 1'b0;
    m_armed = 1'b0;
    repeat (3) pulse(100, 40);
    chk("hold_duty", duty, last_exp.duty);
    chk("hold_period", period, last_exp.per);
    chk("hold_high", high_time, last_exp.hi);
    chk("hold_lost", lost, last_exp.lost);
    step();
    ena   = 1'b1;
    m_ena = 1'b1;
    step();
    repeat (3) pulse(100, 50);

    repeat (40) step();
    chk("results_drained", q.size(), 0);
    chk("overruns_drained", oq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
